// File: rtl/godson_rst_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : godson_rst_pkg
//  Purpose  : State encoding, reset-cause codes and output decode shared by
//             the godson reset sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package godson_rst_pkg;

  // Sequencer states (3-bit encoding)
  localparam logic [2:0] ST_POR    = 3'd0;
  localparam logic [2:0] ST_LOCK   = 3'd1;
  localparam logic [2:0] ST_SYS    = 3'd2;
  localparam logic [2:0] ST_PERIPH = 3'd3;
  localparam logic [2:0] ST_CPU    = 3'd4;
  localparam logic [2:0] ST_RUN    = 3'd5;
  localparam logic [2:0] ST_WARM   = 3'd6;

  typedef logic [1:0] cause_t;

  localparam cause_t CAUSE_POR  = 2'b00;
  localparam cause_t CAUSE_WDT  = 2'b01;
  localparam cause_t CAUSE_SW   = 2'b10;
  localparam cause_t CAUSE_LOCK = 2'b11;

  typedef struct packed {
    logic sys_rstn;
    logic periph_rstn;
    logic cpu_rstn;
    logic boot_done;
  } rst_out_t;

  // Reset-line levels implied by a state
  function automatic rst_out_t decode_state(input logic [2:0] st);
    rst_out_t o;
    o = '0;
    case (st)
      ST_SYS:    o.sys_rstn = 1'b1;
      ST_PERIPH,
      ST_CPU: begin
        o.sys_rstn    = 1'b1;
        o.periph_rstn = 1'b1;
      end
      ST_RUN:    o = 4'b1111;
      ST_WARM:   o.sys_rstn = 1'b1;
      default:   o = '0;
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/godson_rst_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : godson_rst_seq_if
//  Purpose  : Board/SoC-side signal bundle of the reset sequencer.
//             slave  = the sequencer itself, master = the surrounding system.
//  Revision : 1.0  initial release
// ============================================================================
interface godson_rst_seq_if;
  import godson_rst_pkg::*;

  logic   pll_lock;
  logic   dbg_hold;
  logic   wdt_rst_req;
  logic   sw_rst_req;
  logic   sys_rstn;
  logic   periph_rstn;
  logic   cpu_rstn;
  logic   boot_done;
  logic   lock_fail;
  cause_t rst_cause;

  modport slave (
    input  pll_lock, dbg_hold, wdt_rst_req, sw_rst_req,
    output sys_rstn, periph_rstn, cpu_rstn, boot_done, lock_fail, rst_cause
  );

  modport master (
    output pll_lock, dbg_hold, wdt_rst_req, sw_rst_req,
    input  sys_rstn, periph_rstn, cpu_rstn, boot_done, lock_fail, rst_cause
  );
endinterface
`default_nettype wire

// File: rtl/godson_rst_seq_sync2.sv
`default_nettype none
// ============================================================================
//  Module   : godson_sync2
//  Purpose  : Two-flop synchroniser with asynchronous clear to 0.
//  Revision : 1.0  initial release
// ============================================================================
module godson_sync2 (
  input  wire logic i_clk,
  input  wire logic i_rst_n,
  input  wire logic i_d,
  output logic      o_q
);

  logic r_meta;
  logic r_q;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/godson_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : godson_rst_seq
//  Purpose  : Staged reset sequencer: POR -> PLL lock -> SYS -> PERIPH -> CPU
//             -> RUN, with debug hold, warm resets and lock-loss recovery.
//  Revision : 1.0  initial release
// ============================================================================
module godson_rst_seq
  import godson_rst_pkg::*;
#(
  parameter int STAGE_DLY  = 16,
  parameter int LOCK_TMO   = 4096,
  parameter int WARM_PULSE = 8,
  parameter int CNT_W      = 13
) (
  input  wire logic          CLK50M,
  input  wire logic          RSTN,
  godson_rst_seq_if.slave    bus
);

  // Terminal counts: a timed stage of N cycles leaves when the counter is N-1
  localparam logic [CNT_W-1:0] c_stg_last  = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] c_tmo_last  = CNT_W'(LOCK_TMO - 1);
  localparam logic [CNT_W-1:0] c_warm_last = CNT_W'(WARM_PULSE - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_lock_s;
  logic             w_lock_tmo;
  logic             w_timed;
  cause_t           w_cause;
  cause_t           r_cause;
  logic             r_lock_fail;
  rst_out_t         r_out;
  rst_out_t         w_out;

  godson_sync2 u_lock_sync (
    .i_clk   (CLK50M),
    .i_rst_n (RSTN),
    .i_d     (bus.pll_lock),
    .o_q     (w_lock_s)
  );

  // Next-state, lock-timeout flag and next reset cause
  always_comb begin
    w_next     = r_state;
    w_lock_tmo = 1'b0;
    w_cause    = r_cause;
    case (r_state)
      ST_POR:    if (r_cnt == c_stg_last) w_next = ST_LOCK;
      ST_LOCK: begin
        if (w_lock_s) begin
          w_next = ST_SYS;
        end else if (r_cnt == c_tmo_last) begin
          w_next     = ST_SYS;
          w_lock_tmo = 1'b1;
        end
      end
      ST_SYS:    if (r_cnt == c_stg_last) w_next = ST_PERIPH;
      ST_PERIPH: if (r_cnt == c_stg_last) w_next = ST_CPU;
      ST_CPU:    if (!bus.dbg_hold) w_next = ST_RUN;
      ST_RUN: begin
        if (!w_lock_s) begin
          w_next  = ST_LOCK;
          w_cause = CAUSE_LOCK;
        end else if (bus.wdt_rst_req) begin
          w_next  = ST_WARM;
          w_cause = CAUSE_WDT;
        end else if (bus.sw_rst_req) begin
          w_next  = ST_WARM;
          w_cause = CAUSE_SW;
        end
      end
      ST_WARM:   if (r_cnt == c_warm_last) w_next = ST_PERIPH;
      default:   w_next = ST_POR;
    endcase
  end

  // Only timed stages advance the counter; CPU/RUN keep it at zero
  always_comb begin
    w_timed = (r_state == ST_POR)    || (r_state == ST_LOCK) ||
              (r_state == ST_SYS)    || (r_state == ST_PERIPH) ||
              (r_state == ST_WARM);
    w_out   = decode_state(w_next);
  end

  // State, counter and registered outputs (decoded from next state)
  always_ff @(posedge CLK50M or negedge RSTN) begin
    if (!RSTN) begin
      r_state     <= ST_POR;
      r_cnt       <= '0;
      r_cause     <= CAUSE_POR;
      r_lock_fail <= 1'b0;
      r_out       <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (w_timed) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_cause <= w_cause;
      if (w_lock_tmo) begin
        r_lock_fail <= 1'b1;
      end
      r_out <= w_out;
    end
  end

  assign bus.sys_rstn    = r_out.sys_rstn;
  assign bus.periph_rstn = r_out.periph_rstn;
  assign bus.cpu_rstn    = r_out.cpu_rstn;
  assign bus.boot_done   = r_out.boot_done;
  assign bus.lock_fail   = r_lock_fail;
  assign bus.rst_cause   = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_godson_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_godson_rst_seq
//  Purpose  : Directed self-checking bench for godson_rst_seq
//             (STAGE_DLY=4, LOCK_TMO=32, WARM_PULSE=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_godson_rst_seq;

  logic CLK50M;
  logic RSTN;
  int   total;
  int   bad;

  godson_rst_seq_if bus ();

  godson_rst_seq #(
    .STAGE_DLY  (4),
    .LOCK_TMO   (32),
    .WARM_PULSE (3),
    .CNT_W      (13)
  ) dut (
    .CLK50M (CLK50M),
    .RSTN   (RSTN),
    .bus    (bus)
  );

  initial CLK50M = 1'b0;
  always #5 CLK50M = ~CLK50M;

  logic [3:0] w_obs;
  assign w_obs = {bus.sys_rstn, bus.periph_rstn, bus.cpu_rstn, bus.boot_done};

  // Advance one clock and sample just after the edge
  task automatic tick();
    @(posedge CLK50M);
    #1;
  endtask

  task automatic test_reset();
    RSTN            = 1'b0;
    bus.pll_lock    = 1'b1;
    bus.dbg_hold    = 1'b0;
    bus.wdt_rst_req = 1'b0;
    bus.sw_rst_req  = 1'b0;
    repeat (3) tick();
    total++;
    if ({w_obs, bus.lock_fail, bus.rst_cause} !== 7'b0) begin
      bad++;
      $display("FAIL reset_state: got %b required 0000000", {w_obs, bus.lock_fail, bus.rst_cause});
    end
  endtask

  // Cold boot with PLL locked: sys at edge 5, periph at 9, cpu/boot at 14
  task automatic test_cold_boot();
    logic [3:0] exp;
    bus.pll_lock = 1'b1;
    bus.dbg_hold = 1'b0;
    RSTN = 1'b0;
    tick();
    RSTN = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      exp = {e >= 5, e >= 9, e >= 14, e >= 14};
      total++;
      if (w_obs !== exp) begin
        bad++;
        $display("FAIL cold_boot_e%0d: got %b required %b", e, w_obs, exp);
      end
    end
    total++;
    if ({bus.lock_fail, bus.rst_cause} !== 3'b000) begin
      bad++;
      $display("FAIL cold_boot_flags: got %b required 000", {bus.lock_fail, bus.rst_cause});
    end
  endtask

  // PLL never locks: timeout at edge 36, RUN at 45, lock loss back to LOCK at 46
  task automatic test_lock_timeout();
    logic [3:0] exp;
    logic [2:0] exp_f;
    bus.pll_lock = 1'b0;
    RSTN = 1'b0;
    tick();
    RSTN = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      tick();
      exp   = {(e >= 36 && e < 46), (e >= 40 && e < 46), e == 45, e == 45};
      exp_f = {e >= 36, (e >= 46) ? 2'b11 : 2'b00};
      total++;
      if ({w_obs, bus.lock_fail, bus.rst_cause} !== {exp, exp_f}) begin
        bad++;
        $display("FAIL lock_tmo_e%0d: got %b required %b", e,
                 {w_obs, bus.lock_fail, bus.rst_cause}, {exp, exp_f});
      end
    end
  endtask

  // Debug hold keeps CPU in reset until released
  task automatic test_dbg_hold();
    bus.pll_lock = 1'b1;
    bus.dbg_hold = 1'b1;
    RSTN = 1'b0;
    tick();
    RSTN = 1'b1;
    repeat (13) tick();
    for (int e = 13; e <= 113; e++) begin
      total++;
      if (w_obs !== 4'b1100) begin
        bad++;
        $display("FAIL dbg_hold_e%0d: got %b required 1100", e, w_obs);
      end
      if (e < 113) tick();
    end
    bus.dbg_hold = 1'b0;
    tick();
    total++;
    if (w_obs !== 4'b1111) begin
      bad++;
      $display("FAIL dbg_release: got %b required 1111", w_obs);
    end
  endtask

  // WDT and SW request together from RUN: WDT wins, warm sequence follows
  task automatic test_warm_wdt();
    logic [3:0] exp;
    bus.wdt_rst_req = 1'b1;
    bus.sw_rst_req  = 1'b1;
    tick();
    bus.wdt_rst_req = 1'b0;
    bus.sw_rst_req  = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      exp = {1'b1, j >= 4, j >= 9, j >= 9};
      total++;
      if ({w_obs, bus.rst_cause} !== {exp, 2'b01}) begin
        bad++;
        $display("FAIL warm_wdt_j%0d: got %b required %b", j, {w_obs, bus.rst_cause}, {exp, 2'b01});
      end
      tick();
    end
  endtask

  // SW request during PERIPH ignored; held SW request in RUN repeats warm resets
  task automatic test_sw_level();
    RSTN = 1'b0;
    tick();
    RSTN = 1'b1;
    repeat (9) tick();
    bus.sw_rst_req = 1'b1;
    tick();
    bus.sw_rst_req = 1'b0;
    repeat (4) tick();
    total++;
    if ({w_obs, bus.rst_cause} !== 6'b111100) begin
      bad++;
      $display("FAIL sw_ignored: got %b required 111100", {w_obs, bus.rst_cause});
    end
    repeat (2) tick();
    total++;
    if ({w_obs, bus.rst_cause} !== 6'b111100) begin
      bad++;
      $display("FAIL run_stable: got %b required 111100", {w_obs, bus.rst_cause});
    end
    bus.sw_rst_req = 1'b1;
    tick();
    total++;
    if ({w_obs, bus.rst_cause} !== 6'b100010) begin
      bad++;
      $display("FAIL sw_warm: got %b required 100010", {w_obs, bus.rst_cause});
    end
    repeat (8) tick();
    total++;
    if ({w_obs, bus.rst_cause} !== 6'b111110) begin
      bad++;
      $display("FAIL sw_rerun: got %b required 111110", {w_obs, bus.rst_cause});
    end
    tick();
    bus.sw_rst_req = 1'b0;
    total++;
    if ({w_obs, bus.rst_cause} !== 6'b100010) begin
      bad++;
      $display("FAIL sw_level_again: got %b required 100010", {w_obs, bus.rst_cause});
    end
  endtask

  // Async RSTN assertion mid-WARM, then a full cold boot
  task automatic test_rstn_mid_warm();
    #2;
    RSTN = 1'b0;
    #1;
    total++;
    if ({w_obs, bus.lock_fail, bus.rst_cause} !== 7'b0) begin
      bad++;
      $display("FAIL async_reset: got %b required 0000000", {w_obs, bus.lock_fail, bus.rst_cause});
    end
    test_cold_boot();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_cold_boot();
    test_lock_timeout();
    test_dbg_hold();
    test_warm_wdt();
    test_sw_level();
    test_rstn_mid_warm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
